// File: rtl/gcd_req_scheduler_if.sv
// Handshake bundle between the requesters, the GCD request scheduler and the shared GCD engine.
interface gcd_req_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic [NREQ-1:0]   resp_ack;
  logic              gcd_go;
  logic [W-1:0]      gcd_a;
  logic [W-1:0]      gcd_b;
  logic              gcd_done;
  logic [W-1:0]      gcd_result;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ack, gcd_done, gcd_result,
    output req_ready, resp_valid, resp_data, resp_err, gcd_go, gcd_a, gcd_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ack, gcd_done, gcd_result,
    input  req_ready, resp_valid, resp_data, resp_err, gcd_go, gcd_a, gcd_b, busy
  );
endinterface

// File: rtl/gcd_req_scheduler.sv
// Round-robin scheduler sharing one subtract-loop GCD engine among NREQ requesters,
// with local zero-operand bypass and a WAIT timeout.
module gcd_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  gcd_req_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  CNT_TERM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  logic [1:0]      state_r, state_s;
  logic [IDW-1:0]  id_r, id_s;
  logic [IDW-1:0]  last_grant_r, last_grant_s;
  logic [W-1:0]    a_r, a_s;
  logic [W-1:0]    b_r, b_s;
  logic [W-1:0]    result_r, result_s;
  logic            err_r, err_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            go_r, go_s;
  logic [NREQ-1:0] req_ready_r;
  logic [NREQ-1:0] resp_valid_r;
  logic            busy_r;

  logic [IDW-1:0]  scan_s;
  logic [IDW-1:0]  pick_s;
  logic            found_s;
  logic [W-1:0]    a_sel_s;
  logic [W-1:0]    b_sel_s;

  // Round-robin pick: first pending requester after last_grant, wrapping around.
  always_comb begin
    scan_s  = '0;
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_s = IDW'((int'(last_grant_r) + k + 32'sd1) % NREQ);
      if (!found_s && bus.req_valid[scan_s]) begin
        found_s = 1'b1;
        pick_s  = scan_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the picked requester.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_s == IDW'(k)) begin
        a_sel_s = bus.req_a[k*W +: W];
        b_sel_s = bus.req_b[k*W +: W];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP controller.
  always_comb begin
    state_s      = state_r;
    id_s         = id_r;
    last_grant_s = last_grant_r;
    a_s          = a_r;
    b_s          = b_r;
    result_s     = result_r;
    err_s        = err_r;
    cnt_s        = cnt_r;
    go_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_ISSUE;
          id_s    = pick_s;
          a_s     = a_sel_s;
          b_s     = b_sel_s;
          // The engine never terminates on a zero operand, so only start it for nonzero pairs.
          go_s    = (a_sel_s != '0) && (b_sel_s != '0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (a_r == '0) begin
          result_s = b_r;
          err_s    = 1'b0;
          state_s  = ST_RESP;
        end else if (b_r == '0) begin
          result_s = a_r;
          err_s    = 1'b0;
          state_s  = ST_RESP;
        end else begin
          cnt_s    = '0;
          state_s  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (bus.gcd_done) begin
          result_s = bus.gcd_result;
          err_s    = 1'b0;
          state_s  = ST_RESP;
        end else if (cnt_r == CNT_TERM) begin
          result_s = '0;
          err_s    = 1'b1;
          state_s  = ST_RESP;
        end else begin
          state_s  = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (|(bus.resp_ack & onehot(id_r))) begin
          state_s      = ST_IDLE;
          last_grant_s = id_r;
        end else begin
          state_s      = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are computed from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      id_r         <= '0;
      last_grant_r <= LAST_ID;
      a_r          <= '0;
      b_r          <= '0;
      result_r     <= '0;
      err_r        <= 1'b0;
      cnt_r        <= '0;
      go_r         <= 1'b0;
      req_ready_r  <= '0;
      resp_valid_r <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      id_r         <= id_s;
      last_grant_r <= last_grant_s;
      a_r          <= a_s;
      b_r          <= b_s;
      result_r     <= result_s;
      err_r        <= err_s;
      cnt_r        <= cnt_s;
      go_r         <= go_s;
      req_ready_r  <= (state_s == ST_ISSUE) ? onehot(id_s) : '0;
      resp_valid_r <= (state_s == ST_RESP) ? onehot(id_s) : '0;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = result_r;
  assign bus.resp_err   = err_r;
  assign bus.gcd_go     = go_r;
  assign bus.gcd_a      = a_r;
  assign bus.gcd_b      = b_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_gcd_req_scheduler.sv
// Directed bench for gcd_req_scheduler with a behavioural subtract-loop GCD engine stub.
module tb_gcd_req_scheduler;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_req_scheduler_if #(.NREQ(NREQ), .W(W)) bus();

  gcd_req_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int go_cnt = 0;
  logic eng_en = 1'b1;
  logic [7:0] eng_cnt;
  logic [W-1:0] eng_res;

  function automatic logic [W-1:0] gcd_val(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    x = a; y = b;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
    end
    return x;
  endfunction

  function automatic logic [7:0] gcd_iters(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    logic [7:0] n;
    x = a; y = b; n = 8'd0;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
      n = n + 8'd1;
    end
    return n;
  endfunction

  // Engine stub: done 4 cycles after go for equal operands, +3 per subtract step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gcd_done   <= 1'b0;
      bus.gcd_result <= '0;
      eng_cnt        <= 8'd0;
      eng_res        <= '0;
    end else begin
      bus.gcd_done <= 1'b0;
      if (bus.gcd_go && eng_en) begin
        eng_res <= gcd_val(bus.gcd_a, bus.gcd_b);
        eng_cnt <= 8'd3 + 8'd3 * gcd_iters(bus.gcd_a, bus.gcd_b);
      end else if (eng_cnt != 8'd0) begin
        if (eng_cnt == 8'd1) begin
          bus.gcd_done   <= 1'b1;
          bus.gcd_result <= eng_res;
        end
        eng_cnt <= eng_cnt - 8'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.gcd_go) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] got);
    int t = 0;
    while (bus.req_ready == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    got = bus.req_ready;
    check("ready_wait", 32'(got != '0), 32'd1);
  endtask

  task automatic wait_resp();
    int t = 0;
    while (bus.resp_valid == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("resp_wait", 32'(bus.resp_valid != '0), 32'd1);
  endtask

  task automatic ack(input logic [NREQ-1:0] bits);
    bus.resp_ack = bits;
    @(negedge clk);
    bus.resp_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] rr_exp [6];
    logic [W-1:0] zb_a [3];
    logic [W-1:0] zb_b [3];
    logic [W-1:0] zb_r [3];
    int g0;
    int n;
    int seen;

    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    zb_a = '{8'd0, 8'd17, 8'd0};
    zb_b = '{8'd35, 8'd0, 8'd0};
    zb_r = '{8'd35, 8'd17, 8'd0};

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ack = '0;
    step(2);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_go", 32'(bus.gcd_go), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Round robin over requesters 0,1,3 with 9,6 everywhere.
    bus.req_a = {4{8'd9}};
    bus.req_b = {4{8'd6}};
    bus.req_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_ready(g);
      check("rr_grant", 32'(g), 32'(rr_exp[i]));
      wait_resp();
      check("rr_data", 32'(bus.resp_data), 32'd3);
      ack(g);
    end
    bus.req_valid = '0;
    step(1);

    // Single request 12,8 on requester 0.
    bus.req_a[7:0] = 8'd12;
    bus.req_b[7:0] = 8'd8;
    g0 = go_cnt;
    bus.req_valid = 4'b0001;
    wait_ready(g);
    check("single_ready", 32'(g), 32'h1);
    check("single_go", 32'(bus.gcd_go), 32'd1);
    check("single_gcd_a", 32'(bus.gcd_a), 32'd12);
    check("single_busy", 32'(bus.busy), 32'd1);
    bus.req_valid = '0;
    step(1);
    check("single_go_pulse", 32'(bus.gcd_go), 32'd0);
    wait_resp();
    check("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("single_data", 32'(bus.resp_data), 32'd4);
    check("single_err", 32'(bus.resp_err), 32'd0);
    check("single_go_count", 32'(go_cnt - g0), 32'd1);
    ack(4'b0001);
    check("single_idle_busy", 32'(bus.busy), 32'd0);
    check("single_idle_valid", 32'(bus.resp_valid), 32'd0);

    // Zero operands on requester 2 resolve without starting the engine.
    for (int i = 0; i < 3; i++) begin
      bus.req_a[2*W +: W] = zb_a[i];
      bus.req_b[2*W +: W] = zb_b[i];
      g0 = go_cnt;
      bus.req_valid = 4'b0100;
      wait_ready(g);
      check("zero_ready", 32'(g), 32'h4);
      bus.req_valid = '0;
      wait_resp();
      check("zero_data", 32'(bus.resp_data), 32'(zb_r[i]));
      check("zero_err", 32'(bus.resp_err), 32'd0);
      check("zero_no_go", 32'(go_cnt - g0), 32'd0);
      ack(4'b0100);
    end

    // Timeout: ISSUE, then TIMEOUT WAIT cycles, then RESP.
    eng_en = 1'b0;
    bus.req_a[W +: W] = 8'd5;
    bus.req_b[W +: W] = 8'd3;
    bus.req_valid = 4'b0010;
    wait_ready(g);
    check("to_ready", 32'(g), 32'h2);
    check("to_go", 32'(bus.gcd_go), 32'd1);
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 100) begin
      step(1);
      n++;
    end
    check("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check("to_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("to_err", 32'(bus.resp_err), 32'd1);
    check("to_data", 32'(bus.resp_data), 32'd0);
    ack(4'b0010);
    eng_en = 1'b1;
    bus.req_a[W +: W] = 8'd12;
    bus.req_b[W +: W] = 8'd8;
    bus.req_valid = 4'b0010;
    wait_ready(g);
    check("after_to_ready", 32'(g), 32'h2);
    bus.req_valid = '0;
    wait_resp();
    check("after_to_data", 32'(bus.resp_data), 32'd4);
    check("after_to_err", 32'(bus.resp_err), 32'd0);
    ack(4'b0010);

    // Backpressure on requester 2 with a stray ack on bit 1.
    bus.req_a[2*W +: W] = 8'd21;
    bus.req_b[2*W +: W] = 8'd14;
    bus.req_valid = 4'b0100;
    wait_ready(g);
    bus.req_valid = '0;
    wait_resp();
    check("bp_data_first", 32'(bus.resp_data), 32'd7);
    step(10);
    check("bp_valid_held", 32'(bus.resp_valid), 32'h4);
    check("bp_data_held", 32'(bus.resp_data), 32'd7);
    ack(4'b0010);
    check("bp_stray_valid", 32'(bus.resp_valid), 32'h4);
    check("bp_stray_data", 32'(bus.resp_data), 32'd7);
    check("bp_stray_busy", 32'(bus.busy), 32'd1);
    ack(4'b0100);
    check("bp_release_busy", 32'(bus.busy), 32'd0);
    check("bp_release_valid", 32'(bus.resp_valid), 32'd0);

    // Reset while waiting on a silent engine.
    eng_en = 1'b0;
    bus.req_a = {4{8'd9}};
    bus.req_b = {4{8'd6}};
    bus.req_valid = 4'b0001;
    wait_ready(g);
    bus.req_valid = '0;
    step(3);
    check("mid_wait_busy", 32'(bus.busy), 32'd1);
    check("mid_wait_gcd_a", 32'(bus.gcd_a), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_gcd_a", 32'(bus.gcd_a), 32'd0);
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd0);
    step(2);
    rst_n = 1'b1;
    eng_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.resp_valid != '0) seen++;
    end
    check("arst_no_resp", 32'(seen), 32'd0);
    bus.req_valid = 4'b1111;
    wait_ready(g);
    check("arst_first_grant", 32'(g), 32'h1);
    bus.req_valid = '0;
    wait_resp();
    check("arst_data", 32'(bus.resp_data), 32'd3);
    ack(g);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
